eth_sw_top: RTL and testbench
=============================

// Module: eth_sw_top
// PURPOSE
//  2x2 packet switch between Ethernet-style ingress ports A and B and egress ports A and B.
//  - Each packet is framed by sop/eop.
//  - The first (sop) word's byte [7:0] selects the egress port.
//  - Per-path FIFOs buffer the packet.
//  - Each egress port arbitrates between the two ingress ports at packet granularity and drains on the shared rd_en.
// PARAMETERS
//  DATA_W     32     data word width
//  DEPTH      16     words per path FIFO (power of 2); 4 FIFOs: A->A, A->B, B->A, B->B
//  PORTA_ADDR 8'hAA  destination address mapped to egress A
//  PORTB_ADDR 8'hBB  destination address mapped to egress B
// PORTS
//  clk              in   1      single clock, all logic on rising edge
//  rstn             in   1      synchronous reset, active-high (asserted = 1)
//  indataA/B        in   DATA_W ingress data, port A/B
//  insopA/B         in   1      start-of-packet qualifier, port A/B
//  ineopA/B         in   1      end-of-packet qualifier, port A/B
//  rd_en            in   1      egress read enable, shared by both egress ports
//  outdataA/B       out  DATA_W egress data, port A/B
//  outsopA/B        out  1      egress start-of-packet
//  outeopA/B        out  1      egress end-of-packet
//  portAstall_full  out  1      ingress A cannot accept (a FIFO fed by A is full)
//  portBstall_full  out  1      ingress B cannot accept
//  portAstall_empty out  1      egress A has nothing queued (A->A and B->A empty)
//  portBstall_empty out  1      egress B has nothing queued
// BEHAVIOUR
//  - Reset (rstn=1 at edge): all FIFO pointers/counts 0; all out* = 0; stall_full = 0; stall_empty = 1.
//    Ingress and arbiter FSMs go to IDLE; round-robin pointer favours ingress A.
//  - FIFO entry = {sop, eop, data}.
//  - Ingress FSM per port: IDLE / FWD / DROP.
//    - IDLE: sop word decodes data[7:0]. PORTA_ADDR -> FWD to egress A; PORTB_ADDR -> FWD to egress B; any other value -> DROP.
//    - FWD/DROP: words are written (FWD) or discarded (DROP) until an eop word, then back to IDLE.
//    - sop+eop in the same cycle is a 1-word packet.
//    - sop seen while in FWD/DROP restarts decode (new packet). The truncated packet is not repaired.
//    - Words outside a packet (no preceding sop) are ignored.
//  - Write into a full FIFO: the word is discarded and count is unchanged. Upstream must honour stall_full.
//  - stall_full is combinational from registered counts and is high while either FIFO of that ingress is full.
//  - stall_empty is combinational and high when both FIFOs feeding that egress port are empty.
//  - Egress arbiter per port: IDLE / SEND(src).
//    - IDLE: choose a non-empty source FIFO whose head word has sop. When both qualify, the round-robin pointer decides.
//    - SEND: stay locked to src until its eop word is read; then flip the pointer to the other source and return to IDLE.
//  - Read timing: rd_en=1 with the locked/selected source non-empty pops one word.
//    - outdata/outsop/outeop are registered, valid the cycle after the pop (latency 1).
//    - Otherwise out* = 0 next cycle.
//  - Egress A and B are independent; both may pop in the same cycle.
//  - Simultaneous write and read on the same FIFO: count unchanged. A read of a full FIFO frees space for a write the same cycle.
//  - Pointers wrap modulo DEPTH.
//  - Reset mid-packet: all queued data is discarded and FSMs return to IDLE.
// CONFIGURATION
//  ETH_SW_BROADCAST_EN
//    - defined: sop address 8'hFF writes the packet into both FIFOs of that ingress.
//      - The packet is accepted only if both are not full at sop; otherwise DROP.
//      - A full FIFO during the body discards that word for that path only.
//    - undefined: 8'hFF is an unknown address and the packet is dropped.
// TESTING
//  - Reset: hold rstn=1 for 2 clocks -> all out*=0, stall_full=0, portA/Bstall_empty=1.
//  - A->B: 3 words {0x...BB, 0x11, 0x22} on port A, sop on word1, eop on word3, then rd_en=1
//    -> outdataB = 0x...BB, 0x11, 0x22 one cycle after each pop; outsopB on 1st word; outeopB on 3rd; egress A idle.
//  - Contention: A and B both send 2-word packets to egress A in the same cycle
//    -> egress A outputs A's packet complete, then B's; words are never interleaved.
//  - Full: 17 words to A->A with rd_en=0 -> portAstall_full=1 after the 16th write; 17th word is lost.
//    Then 1 pop -> stall_full=0.
//  - Unknown address 0x...CC -> packet dropped; both stall_empty stay 1.
//  - ETH_SW_BROADCAST_EN: address 0x...FF from B -> identical packet appears on egress A and B.
//    With the macro undefined -> dropped.

Source files
------------

// File: rtl/eth_sw_top.sv
// 2x2 packet switch: ingress A/B -> four path FIFOs -> per-egress packet-granular round-robin arbiters.
// Optional ETH_SW_BROADCAST_EN: sop address 8'hFF replicates a packet to both egress ports.
module eth_sw_top #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 16,
  parameter logic [7:0]  PORTA_ADDR = 8'hAA,
  parameter logic [7:0]  PORTB_ADDR = 8'hBB
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] indataA,
  input  logic [DATA_W-1:0] indataB,
  input  logic              insopA,
  input  logic              insopB,
  input  logic              ineopA,
  input  logic              ineopB,
  input  logic              rd_en,
  output logic [DATA_W-1:0] outdataA,
  output logic [DATA_W-1:0] outdataB,
  output logic              outsopA,
  output logic              outsopB,
  output logic              outeopA,
  output logic              outeopB,
  output logic              portAstall_full,
  output logic              portBstall_full,
  output logic              portAstall_empty,
  output logic              portBstall_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + 2;

  localparam logic [1:0] ING_IDLE = 2'd0;
  localparam logic [1:0] ING_FWD  = 2'd1;
  localparam logic [1:0] ING_DROP = 2'd2;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_SEND_A = 2'd1;
  localparam logic [1:0] ARB_SEND_B = 2'd2;

  // FIFO index = src*2 + dst : 0 A->A, 1 A->B, 2 B->A, 3 B->B
  logic [3:0]        wr;
  logic [3:0]        pop;
  logic [3:0]        full;
  logic [3:0]        empty;
  logic [EW-1:0]     head [4];

  logic [DATA_W-1:0] in_data [2];
  logic              in_sop  [2];
  logic              in_eop  [2];
  logic [1:0]        ing_wmask [2];
  logic [1:0]        arb_pop   [2];

  logic [DATA_W-1:0] eg_data [2];
  logic              eg_sop  [2];
  logic              eg_eop  [2];

  assign in_data[0] = indataA;
  assign in_data[1] = indataB;
  assign in_sop[0]  = insopA;
  assign in_sop[1]  = insopB;
  assign in_eop[0]  = ineopA;
  assign in_eop[1]  = ineopB;

  genvar gf, gp, ge;

  for (gf = 0; gf < 4; gf++) begin : g_fifo
    localparam int SRC = gf / 2;
    localparam int DST = gf % 2;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    assign full[gf]  = (cnt == (AW+1)'(DEPTH));
    assign empty[gf] = (cnt == '0);
    assign head[gf]  = mem[rd_ptr];
    assign pop[gf]   = arb_pop[DST][SRC];
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign wr[gf]    = ing_wmask[SRC][DST] && (!full[gf] || pop[gf]);

    always_ff @(posedge clk) begin
      if (rstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr[gf])  wr_ptr <= wr_ptr + AW'(1);
        if (pop[gf]) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + {{AW{1'b0}}, wr[gf]} - {{AW{1'b0}}, pop[gf]};
      end
    end

    always_ff @(posedge clk) begin
      if (wr[gf]) mem[wr_ptr] <= {in_sop[SRC], in_eop[SRC], in_data[SRC]};
    end
  end

  for (gp = 0; gp < 2; gp++) begin : g_ing
    localparam int F_TO_A = 2 * gp;
    localparam int F_TO_B = 2 * gp + 1;

    logic [1:0] st, st_nxt;
    logic [1:0] mask, mask_nxt;
    logic [1:0] wmask;
    logic [1:0] dec;

    // mask bit0 = egress A, bit1 = egress B; a zero decode means drop
    always_comb begin
      st_nxt   = st;
      mask_nxt = mask;
      wmask    = 2'b00;
      dec      = 2'b00;
      if (in_sop[gp]) begin
        if (in_data[gp][7:0] == PORTA_ADDR) dec = 2'b01;
        else if (in_data[gp][7:0] == PORTB_ADDR) dec = 2'b10;
`ifdef ETH_SW_BROADCAST_EN
        else if (in_data[gp][7:0] == 8'hFF && !full[F_TO_A] && !full[F_TO_B]) dec = 2'b11;
`endif
        wmask    = dec;
        mask_nxt = dec;
        if (in_eop[gp])       st_nxt = ING_IDLE;
        else if (dec != 2'b00) st_nxt = ING_FWD;
        else                   st_nxt = ING_DROP;
      end else if (st == ING_FWD) begin
        wmask = mask;
        if (in_eop[gp]) st_nxt = ING_IDLE;
      end else if (st == ING_DROP) begin
        if (in_eop[gp]) st_nxt = ING_IDLE;
      end
    end

    assign ing_wmask[gp] = wmask;

    always_ff @(posedge clk) begin
      if (rstn) begin
        st   <= ING_IDLE;
        mask <= 2'b00;
      end else begin
        st   <= st_nxt;
        mask <= mask_nxt;
      end
    end
  end

  for (ge = 0; ge < 2; ge++) begin : g_arb
    localparam int FA = ge;
    localparam int FB = 2 + ge;

    logic [1:0]        st, st_nxt;
    logic              rr, rr_nxt;
    logic              qa, qb;
    logic              sel;
    logic              sel_vld;
    logic [1:0]        pop_src;
    logic [EW-1:0]     pop_word_p0;
    logic              pop_vld_p0;
    logic [DATA_W-1:0] out_data_p1;
    logic              out_sop_p1;
    logic              out_eop_p1;

    assign qa = !empty[FA] && head[FA][EW-1];
    assign qb = !empty[FB] && head[FB][EW-1];

    // rr = 0 favours ingress A when both heads carry sop
    always_comb begin
      st_nxt  = st;
      rr_nxt  = rr;
      sel     = 1'b0;
      sel_vld = 1'b0;
      pop_src = 2'b00;
      case (st)
        ARB_IDLE: begin
          sel_vld = qa || qb;
          sel     = (qa && qb) ? rr : qb;
        end
        ARB_SEND_A: begin
          sel     = 1'b0;
          sel_vld = !empty[FA];
        end
        ARB_SEND_B: begin
          sel     = 1'b1;
          sel_vld = !empty[FB];
        end
        default: ;
      endcase
      pop_word_p0 = sel ? head[FB] : head[FA];
      pop_vld_p0  = rd_en && sel_vld;
      if (pop_vld_p0) begin
        pop_src = sel ? 2'b10 : 2'b01;
        if (pop_word_p0[EW-2]) begin
          st_nxt = ARB_IDLE;
          rr_nxt = ~sel;
        end else begin
          st_nxt = sel ? ARB_SEND_B : ARB_SEND_A;
        end
      end
    end

    assign arb_pop[ge] = pop_src;

    // pop stage -> registered egress outputs
    always_ff @(posedge clk) begin
      if (rstn) begin
        st          <= ARB_IDLE;
        rr          <= 1'b0;
        out_data_p1 <= '0;
        out_sop_p1  <= 1'b0;
        out_eop_p1  <= 1'b0;
      end else begin
        st          <= st_nxt;
        rr          <= rr_nxt;
        out_data_p1 <= pop_vld_p0 ? pop_word_p0[DATA_W-1:0] : '0;
        out_sop_p1  <= pop_vld_p0 && pop_word_p0[EW-1];
        out_eop_p1  <= pop_vld_p0 && pop_word_p0[EW-2];
      end
    end

    assign eg_data[ge] = out_data_p1;
    assign eg_sop[ge]  = out_sop_p1;
    assign eg_eop[ge]  = out_eop_p1;
  end

  assign outdataA = eg_data[0];
  assign outdataB = eg_data[1];
  assign outsopA  = eg_sop[0];
  assign outsopB  = eg_sop[1];
  assign outeopA  = eg_eop[0];
  assign outeopB  = eg_eop[1];

  assign portAstall_full  = full[0] | full[1];
  assign portBstall_full  = full[2] | full[3];
  assign portAstall_empty = empty[0] & empty[2];
  assign portBstall_empty = empty[1] & empty[3];

endmodule

// File: tb/tb_eth_sw_top.sv
// Bench for eth_sw_top: directed vector table, hand-written corner sequences, and a
// randomized phase checked against a packet-level scoreboard.
module tb_eth_sw_top;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] indataA = '0, indataB = '0;
  logic        insopA = 1'b0, insopB = 1'b0, ineopA = 1'b0, ineopB = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] outdataA, outdataB;
  logic        outsopA, outsopB, outeopA, outeopB;
  logic        portAstall_full, portBstall_full, portAstall_empty, portBstall_empty;

`ifdef ETH_SW_BROADCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  eth_sw_top dut (
    .clk(clk), .rstn(rstn),
    .indataA(indataA), .indataB(indataB),
    .insopA(insopA), .insopB(insopB), .ineopA(ineopA), .ineopB(ineopB),
    .rd_en(rd_en),
    .outdataA(outdataA), .outdataB(outdataB),
    .outsopA(outsopA), .outsopB(outsopB), .outeopA(outeopA), .outeopB(outeopB),
    .portAstall_full(portAstall_full), .portBstall_full(portBstall_full),
    .portAstall_empty(portAstall_empty), .portBstall_empty(portBstall_empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic sa, ea; logic [31:0] da;
    logic sb, eb; logic [31:0] db;
    logic rd;
    logic [31:0] xda; logic xsa, xea;
    logic [31:0] xdb; logic xsb, xeb;
    logic xma, xmb;
  } vec_t;

  vec_t tbl[17];

  // scoreboard: expected {sop,eop,data} per path, index src*2+dst
  logic [33:0] exp_q[4][$];
  int          outst[4];
  bit          act[2];
  int          cur[2];

  function automatic vec_t mk(input logic sa, ea, input logic [31:0] da,
                              input logic sb, eb, input logic [31:0] db, input logic rd,
                              input logic [31:0] xda, input logic xsa, xea,
                              input logic [31:0] xdb, input logic xsb, xeb,
                              input logic xma, xmb);
    vec_t v;
    v.sa = sa; v.ea = ea; v.da = da; v.sb = sb; v.eb = eb; v.db = db; v.rd = rd;
    v.xda = xda; v.xsa = xsa; v.xea = xea; v.xdb = xdb; v.xsb = xsb; v.xeb = xeb;
    v.xma = xma; v.xmb = xmb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sa, ea, input logic [31:0] da,
                       input logic sb, eb, input logic [31:0] db, input logic rd);
    insopA = sa; ineopA = ea; indataA = da;
    insopB = sb; ineopB = eb; indataB = db;
    rd_en = rd;
  endtask

  task automatic mon(input int e, input logic [31:0] d, input logic s, input logic eo);
    int src, path;
    logic ok;
    logic [33:0] ev;
    if (d == 32'h0 && !s && !eo) return;
    src = int'(d[31:28]) - 1;
    n_tests++;
    if (src < 0 || src > 1) begin
      n_fail++;
      $display("FAIL rnd_tag egress %0d: got word %h, required a source-tagged word", e, d);
      return;
    end
    path = src * 2 + e;
    ev = (exp_q[path].size() > 0) ? exp_q[path][0] : '1;
    ok = (exp_q[path].size() > 0) && (ev == {s, eo, d}) &&
         (s ? !act[e] : (act[e] && cur[e] == src));
    if (!ok) begin
      n_fail++;
      $display("FAIL rnd_word egress %0d src %0d: got %h (in_pkt %0d from %0d), required %h",
               e, src, {s, eo, d}, act[e], cur[e], ev);
    end
    if (exp_q[path].size() > 0) begin
      void'(exp_q[path].pop_front());
      outst[path]--;
    end
    if (s) begin
      act[e] = 1'b1;
      cur[e] = src;
    end
    if (eo) act[e] = 1'b0;
  endtask

  initial begin
    int rem[2], gap[2], idx[2], pth[2];
    logic [7:0] addr[2];

    tbl[0]  = mk(1,0,32'hBB,        0,0,32'h0,        0, 32'h0,0,0,        32'h0,0,0,   1,0);
    tbl[1]  = mk(0,0,32'h11,        0,0,32'h0,        0, 32'h0,0,0,        32'h0,0,0,   1,0);
    tbl[2]  = mk(0,1,32'h22,        0,0,32'h0,        0, 32'h0,0,0,        32'h0,0,0,   1,0);
    tbl[3]  = mk(0,0,32'h0,         0,0,32'h0,        1, 32'h0,0,0,        32'hBB,1,0,  1,0);
    tbl[4]  = mk(0,0,32'h0,         0,0,32'h0,        1, 32'h0,0,0,        32'h11,0,0,  1,0);
    tbl[5]  = mk(0,0,32'h0,         0,0,32'h0,        1, 32'h0,0,0,        32'h22,0,1,  1,1);
    tbl[6]  = mk(0,0,32'h0,         0,0,32'h0,        1, 32'h0,0,0,        32'h0,0,0,   1,1);
    tbl[7]  = mk(1,0,32'hA00000AA,  1,0,32'hB00000AA, 0, 32'h0,0,0,        32'h0,0,0,   0,1);
    tbl[8]  = mk(0,1,32'hA1,        0,1,32'hB1,       0, 32'h0,0,0,        32'h0,0,0,   0,1);
    tbl[9]  = mk(0,0,32'h0,         0,0,32'h0,        1, 32'hA00000AA,1,0, 32'h0,0,0,   0,1);
    tbl[10] = mk(0,0,32'h0,         0,0,32'h0,        1, 32'hA1,0,1,       32'h0,0,0,   0,1);
    tbl[11] = mk(0,0,32'h0,         0,0,32'h0,        1, 32'hB00000AA,1,0, 32'h0,0,0,   0,1);
    tbl[12] = mk(0,0,32'h0,         0,0,32'h0,        1, 32'hB1,0,1,       32'h0,0,0,   1,1);
    tbl[13] = mk(0,0,32'h0,         0,0,32'h0,        1, 32'h0,0,0,        32'h0,0,0,   1,1);
    tbl[14] = mk(1,0,32'hCC,        1,1,32'h7BB,      1, 32'h0,0,0,        32'h0,0,0,   1,0);
    tbl[15] = mk(0,1,32'h33,        0,0,32'h0,        1, 32'h0,0,0,        32'h7BB,1,1, 1,1);
    tbl[16] = mk(0,0,32'hAA,        0,0,32'h0,        1, 32'h0,0,0,        32'h0,0,0,   1,1);

    // reset
    drive(0,0,32'h0,0,0,32'h0,0);
    rstn = 1'b1;
    tick;
    tick;
    chk("rst_outA", {outdataA, outsopA, outeopA}, 64'h0);
    chk("rst_outB", {outdataB, outsopB, outeopB}, 64'h0);
    chk("rst_stall", {portAstall_full, portBstall_full, portAstall_empty, portBstall_empty}, 4'b0011);
    rstn = 1'b0;

    // directed vectors: A->B, contention on egress A, unknown address, 1-word packet, stray word
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].sa, tbl[i].ea, tbl[i].da, tbl[i].sb, tbl[i].eb, tbl[i].db, tbl[i].rd);
      tick;
      chk($sformatf("vec%0d_outA", i), {outdataA, outsopA, outeopA}, {tbl[i].xda, tbl[i].xsa, tbl[i].xea});
      chk($sformatf("vec%0d_outB", i), {outdataB, outsopB, outeopB}, {tbl[i].xdb, tbl[i].xsb, tbl[i].xeb});
      chk($sformatf("vec%0d_stall", i),
          {portAstall_empty, portBstall_empty, portAstall_full, portBstall_full},
          {tbl[i].xma, tbl[i].xmb, 2'b00});
    end

    // full: 17 words into A->A without reading
    for (int k = 0; k < 17; k++) begin
      drive(k == 0, k == 16, (k == 0) ? 32'hAA : 32'(32'h1000 + k), 0, 0, 32'h0, 0);
      tick;
      if (k == 14) chk("full_at15", portAstall_full, 1'b0);
      if (k == 15) chk("full_at16", portAstall_full, 1'b1);
    end
    chk("full_after17", {portAstall_full, portBstall_full, portAstall_empty}, 3'b100);
    drive(0,0,32'h0,0,0,32'h0,1);
    tick;
    chk("full_pop1", {outdataA, outsopA, outeopA, portAstall_full}, {32'hAA, 3'b100});
    for (int k = 1; k < 16; k++) begin
      tick;
      chk($sformatf("full_drain%0d", k), {outdataA, outsopA, outeopA}, {32'(32'h1000 + k), 2'b00});
    end
    tick;
    chk("full_lost17", {outdataA, outeopA, portAstall_empty}, {32'h0, 2'b01});

    // reset mid-packet: B->B partially queued, egress A left locked
    drive(0,0,32'h0,1,0,32'hBB,0);
    tick;
    rstn = 1'b1;
    drive(0,0,32'h0,0,0,32'h0,0);
    tick;
    tick;
    rstn = 1'b0;
    chk("rstmid_stall", {portAstall_empty, portBstall_empty, portBstall_full}, 3'b110);
    drive(0,0,32'h0,0,1,32'h99,1);
    tick;
    chk("rstmid_ignored", {portBstall_empty, outdataB}, {1'b1, 32'h0});
    drive(0,0,32'h0,1,0,32'hB00000AA,1);
    tick;
    chk("rstmid_w0", {outdataA, outsopA, outeopA}, 64'h0);
    drive(0,0,32'h0,0,1,32'hB2,1);
    tick;
    chk("rstmid_w1", {outdataA, outsopA, outeopA}, {32'hB00000AA, 2'b10});
    drive(0,0,32'h0,0,0,32'h0,1);
    tick;
    chk("rstmid_w2", {outdataA, outsopA, outeopA}, {32'hB2, 2'b01});

    // broadcast address from B
    drive(0,0,32'h0,1,0,32'hFF,0);
    tick;
    drive(0,0,32'h0,0,1,32'h44,0);
    tick;
    chk("bc_queued", {portAstall_empty, portBstall_empty}, BC ? 2'b00 : 2'b11);
    drive(0,0,32'h0,0,0,32'h0,1);
    tick;
    chk("bc_A0", {outdataA, outsopA, outeopA}, BC ? {32'hFF, 2'b10} : 34'h0);
    chk("bc_B0", {outdataB, outsopB, outeopB}, BC ? {32'hFF, 2'b10} : 34'h0);
    tick;
    chk("bc_A1", {outdataA, outsopA, outeopA}, BC ? {32'h44, 2'b01} : 34'h0);
    chk("bc_B1", {outdataB, outsopB, outeopB}, BC ? {32'h44, 2'b01} : 34'h0);
    tick;

    // randomized traffic; packets start only when the path has room
    for (int p = 0; p < 2; p++) begin
      rem[p] = 0; gap[p] = 0; idx[p] = 0; pth[p] = -1; addr[p] = 8'h0;
      act[p] = 1'b0; cur[p] = 0;
    end
    for (int q = 0; q < 4; q++) outst[q] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic s[2], e[2];
      logic [31:0] d[2];
      for (int p = 0; p < 2; p++) begin
        s[p] = 1'b0; e[p] = 1'b0; d[p] = 32'h0;
        if (rem[p] == 0) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            int len, sel, t;
            logic [7:0] a;
            len = $urandom_range(1, 6);
            sel = $urandom_range(0, 2);
            a = (sel == 0) ? 8'hAA : ((sel == 1) ? 8'hBB : 8'hCC);
            t = (sel == 2) ? -1 : p * 2 + sel;
            if (t < 0 || outst[t] + len <= 15) begin
              rem[p] = len; idx[p] = 0; addr[p] = a; pth[p] = t;
            end
          end
        end
        if (rem[p] > 0) begin
          s[p] = (idx[p] == 0);
          e[p] = (rem[p] == 1);
          d[p] = {4'(p + 1), 20'($urandom), (idx[p] == 0) ? addr[p] : 8'($urandom)};
          if (pth[p] >= 0) begin
            exp_q[pth[p]].push_back({s[p], e[p], d[p]});
            outst[pth[p]]++;
          end
          idx[p]++;
          rem[p]--;
          if (rem[p] == 0) gap[p] = $urandom_range(0, 3);
        end
      end
      drive(s[0], e[0], d[0], s[1], e[1], d[1], $urandom_range(0, 3) != 0);
      tick;
      mon(0, outdataA, outsopA, outeopA);
      mon(1, outdataB, outsopB, outeopB);
    end
    drive(0,0,32'h0,0,0,32'h0,1);
    for (int c = 0; c < 80; c++) begin
      tick;
      mon(0, outdataA, outsopA, outeopA);
      mon(1, outdataB, outsopB, outeopB);
    end
    for (int q = 0; q < 4; q++) chk($sformatf("rnd_left_path%0d", q), exp_q[q].size(), 0);
    chk("rnd_open_pkt", {act[0], act[1]}, 2'b00);
    chk("rnd_idle_stall", {portAstall_empty, portBstall_empty}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
